// File: rtl/cellrv32_uart_image_uploader_if.sv
// cellrv32_uart_image_uploader_if: source-side handshake and serial output bundle of the image uploader
interface cellrv32_uart_image_uploader_if;
    logic        start_i;
    logic [31:0] size_i;
    logic [31:0] csum_i;
    logic [31:0] word_i;
    logic        word_valid_i;
    logic        word_ready_o;
    logic        busy_o;
    logic        done_o;
    logic        txd_o;
    logic        csum_err_o;
    modport master (
        output start_i, size_i, csum_i, word_i, word_valid_i,
        input  word_ready_o, busy_o, done_o, txd_o, csum_err_o
    );
    modport slave (
        input  start_i, size_i, csum_i, word_i, word_valid_i,
        output word_ready_o, busy_o, done_o, txd_o, csum_err_o
    );
endinterface

// File: rtl/cellrv32_uart_image_uploader.sv
// cellrv32_uart_image_uploader: UART 8N1 streamer of bootloader header plus image words; CELLRV32_UPLOADER_CHECK_EN adds checksum verification
module cellrv32_uart_image_uploader #(
    parameter int          CLOCK_FREQUENCY = 50000000,
    parameter int          BAUD_RATE       = 19200,
    parameter logic [31:0] SIGNATURE       = 32'h4788CAFE
) (
    input logic clk_i,
    input logic rst_i,
    cellrv32_uart_image_uploader_if.slave up
);
    localparam int BAUD_DIV = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    if (BAUD_DIV < 2) begin : g_baud_chk
        $fatal(1, "BAUD_DIV must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, HDR, DATA_WAIT, DATA, FINISH} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [1:0]    byte_idx, word_idx;
    logic [29:0]   wcnt;
    logic [31:0]   size_q, csum_q, data_q, cur_word;
    logic [7:0]    cur_byte;
    logic [9:0]    frame;
    logic          sending, bit_end, frame_end, word_end, hdr_end, start_ok, accept, csum_err;

    // frame decode, next-state selection and serial bit selection
    always_comb begin
        sending   = state == HDR || state == DATA;
        bit_end   = sending && baud_cnt == BW'(BAUD_DIV - 1);
        frame_end = bit_end && bit_cnt == 4'd9;
        word_end  = frame_end && byte_idx == 2'd3;
        hdr_end   = word_end && word_idx == 2'd2;
        start_ok  = state == IDLE && up.start_i;
        accept    = state == DATA_WAIT && up.word_valid_i;
        cur_word  = state == DATA ? data_q : word_idx == 2'd0 ? SIGNATURE : word_idx == 2'd1 ? size_q : csum_q;
        cur_byte  = 8'(cur_word >> {byte_idx, 3'b000});
        frame     = {1'b1, cur_byte, 1'b0};
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = start_ok ? HDR : IDLE;
            HDR:       state_nxt = hdr_end ? (wcnt != '0 ? DATA_WAIT : FINISH) : HDR;
            DATA_WAIT: state_nxt = accept ? DATA : DATA_WAIT;
            DATA:      state_nxt = word_end ? (wcnt != '0 ? DATA_WAIT : FINISH) : DATA;
            default:   state_nxt = IDLE;
        endcase
    end

    assign up.word_ready_o = state == DATA_WAIT;
    assign up.busy_o       = sending || state == DATA_WAIT;
    assign up.done_o       = state == FINISH;
    assign up.txd_o        = sending ? frame[bit_cnt] : 1'b1;
    assign up.csum_err_o   = csum_err;

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // baud/bit/byte/word counters plus header and data word capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            word_idx <= '0;
            wcnt     <= '0;
            size_q   <= '0;
            csum_q   <= '0;
            data_q   <= '0;
        end else begin
            baud_cnt <= (!sending || bit_end) ? '0 : baud_cnt + 1'b1;
            bit_cnt  <= (!sending || frame_end) ? 4'd0 : bit_end ? bit_cnt + 4'd1 : bit_cnt;
            byte_idx <= (!sending || word_end) ? 2'd0 : frame_end ? byte_idx + 2'd1 : byte_idx;
            word_idx <= state != HDR ? 2'd0 : word_end ? word_idx + 2'd1 : word_idx;
            if (start_ok) begin
                size_q <= up.size_i & ~32'h3;
                csum_q <= up.csum_i;
                wcnt   <= up.size_i[31:2];
            end
            if (accept) begin
                data_q <= up.word_i;
                wcnt   <= wcnt - 30'd1;
            end
        end
    end

`ifdef CELLRV32_UPLOADER_CHECK_EN
    logic [31:0] sum;

    // running checksum; flag is resolved on entry to FINISH so it is valid alongside done_o
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum      <= '0;
            csum_err <= 1'b0;
        end else begin
            sum      <= start_ok ? up.csum_i : accept ? sum + up.word_i : sum;
            csum_err <= start_ok ? 1'b0 : (state != FINISH && state_nxt == FINISH) ? sum != '0 : csum_err;
        end
    end
`else
    assign csum_err = 1'b0;
`endif
endmodule

// File: tb/tb_cellrv32_uart_image_uploader.sv
// tb_cellrv32_uart_image_uploader: randomized bench with a bit-queue reference model of the uploader
module tb_cellrv32_uart_image_uploader;
    localparam logic [31:0] SIG = 32'h4788CAFE;
    localparam int BD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   chk_en = 0;
    bit   ready_seen = 0;

    logic [31:0] src_q[$];
    logic [7:0]  rx_log[$];
    logic [7:0]  exp_b[$];

    cellrv32_uart_image_uploader_if u();

    cellrv32_uart_image_uploader #(
        .CLOCK_FREQUENCY(76800),
        .BAUD_RATE(19200),
        .SIGNATURE(SIG)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .up(u)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    endfunction

    // reference model: expected txd level per clock held in a queue
    bit          mq[$];
    int          m_words = 0;
    bit          m_busy = 0;
    bit          m_done = 0;
    bit          m_err = 0;
    logic [31:0] m_sum = 0;

    function automatic void push_word(logic [31:0] w);
        logic [9:0] f;
        for (int b = 0; b < 4; b++) begin
            f = {1'b1, w[8*b +: 8], 1'b0};
            for (int k = 0; k < 10; k++) repeat (BD) mq.push_back(f[k]);
        end
    endfunction

    always @(negedge clk) if (chk_en) begin
        check("txd", 32'(u.txd_o), 32'(mq.size() != 0 ? mq[0] : 1'b1));
        check("word_ready", 32'(u.word_ready_o), 32'(m_busy && mq.size() == 0 && m_words != 0));
        check("busy", 32'(u.busy_o), 32'(m_busy));
        check("done", 32'(u.done_o), 32'(m_done));
        check("csum_err", 32'(u.csum_err_o), 32'(m_err));
        if (rst) begin
            mq.delete();
            m_busy = 0; m_done = 0; m_err = 0; m_words = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_busy) begin
            if (u.start_i) begin
                m_busy = 1; m_err = 0;
                m_words = int'(u.size_i >> 2);
                m_sum = u.csum_i;
                push_word(SIG);
                push_word(u.size_i & ~32'h3);
                push_word(u.csum_i);
            end
        end else if (mq.size() != 0) begin
            void'(mq.pop_front());
            if (mq.size() == 0 && m_words == 0) begin
                m_busy = 0;
                m_done = 1;
`ifdef CELLRV32_UPLOADER_CHECK_EN
                m_err = m_sum != 0;
`endif
            end
        end else if (u.word_valid_i) begin
            push_word(u.word_i);
            m_words--;
            m_sum += u.word_i;
        end
    end

    // independent UART receiver logging decoded bytes
    bit         rx_on = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 0;
    always @(negedge clk) if (chk_en) begin
        if (rst) rx_on = 0;
        else if (!rx_on) begin
            if (u.txd_o == 1'b0) begin rx_on = 1; rx_cnt = 0; end
        end else begin
            rx_cnt++;
            if (rx_cnt % BD == 2 && rx_cnt / BD >= 1 && rx_cnt / BD <= 8) rx_sh[rx_cnt / BD - 1] = u.txd_o;
            if (rx_cnt == 9 * BD + 2) rx_log.push_back(rx_sh);
            if (rx_cnt == 10 * BD - 1) rx_on = 0;
        end
    end

    task automatic check_bytes(string name);
        check({name, "_len"}, 32'(rx_log.size()), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < rx_log.size(); i++) check(name, 32'(rx_log[i]), 32'(exp_b[i]));
    endtask

    task automatic upload(input logic [31:0] size, input logic [31:0] csum, input int stall, input bit rnd,
                          input int poke_at, input int rst_at, output int cyc, output logic err);
        int st;
        bit hs;
        bit seen;
        st = stall; cyc = 0; err = 0; seen = 0;
        rx_log.delete();
        @(posedge clk); #1;
        u.start_i = 1; u.size_i = size; u.csum_i = csum;
        @(posedge clk); #1;
        u.start_i = 0; u.size_i = $urandom; u.csum_i = $urandom;
        while (!seen && cyc < 5000) begin
            u.word_valid_i = src_q.size() != 0 && st == 0 && (!rnd || $urandom_range(0, 2) != 0);
            u.word_i = src_q.size() != 0 ? src_q[0] : $urandom;
            @(negedge clk);
            cyc++;
            hs = u.word_ready_o && u.word_valid_i;
            if (u.word_ready_o) begin
                ready_seen = 1;
                if (st != 0) st--;
            end
            if (u.done_o) begin seen = 1; err = u.csum_err_o; end
            @(posedge clk); #1;
            if (hs) void'(src_q.pop_front());
            u.start_i = !seen && cyc == poke_at;
            if (!seen && cyc == poke_at) u.size_i = 32'h20;
            if (cyc == rst_at) begin
                rst = 1;
                @(posedge clk); #1;
                rst = 0;
                u.word_valid_i = 0;
                return;
            end
        end
        u.start_i = 0;
        u.word_valid_i = 0;
        if (!seen) check("done_timeout", 32'(seen), 32'(1));
    endtask

    initial begin
        int cyc;
        logic err;
        int n;
        logic [31:0] w, s, sz;
        u.start_i = 0; u.size_i = 0; u.csum_i = 0; u.word_i = 0; u.word_valid_i = 0;
        @(posedge clk);
        chk_en = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset_txd", 32'(u.txd_o), 32'(1));
        check("reset_busy", 32'(u.busy_o), 32'(0));
        check("reset_done", 32'(u.done_o), 32'(0));
        check("reset_ready", 32'(u.word_ready_o), 32'(0));
        check("reset_csum_err", 32'(u.csum_err_o), 32'(0));

        // header only; a start in the FINISH cycle must be ignored
        ready_seen = 0;
        upload(32'd0, 32'd0, 0, 0, 480, -1, cyc, err);
        check("t1_done_cycle", 32'(cyc), 32'd481);
        check("t1_ready_never", 32'(ready_seen), 32'(0));
        exp_b = '{8'hFE, 8'hCA, 8'h88, 8'h47, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_bytes("t1_bytes");

        // two words, matching checksum
        src_q = '{32'h1, 32'h2};
        upload(32'd8, 32'hFFFFFFFD, 0, 0, -1, -1, cyc, err);
        check("t2_done_cycle", 32'(cyc), 32'd803);
        check("t2_csum_err", 32'(err), 32'(0));
        exp_b = '{8'hFE, 8'hCA, 8'h88, 8'h47, 8'h08, 8'h00, 8'h00, 8'h00, 8'hFD, 8'hFF, 8'hFF, 8'hFF,
                  8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        check_bytes("t2_bytes");

        // bad checksum
        src_q = '{32'h1, 32'h2};
        upload(32'd8, 32'd0, 0, 0, -1, -1, cyc, err);
`ifdef CELLRV32_UPLOADER_CHECK_EN
        check("t3_csum_err", 32'(err), 32'(1));
`else
        check("t3_csum_err", 32'(err), 32'(0));
`endif

        // 37-cycle source stall before the first word
        src_q = '{32'h1, 32'h2};
        upload(32'd8, 32'hFFFFFFFD, 37, 0, -1, -1, cyc, err);
        check("t4_done_cycle", 32'(cyc), 32'd840);
        exp_b = '{8'hFE, 8'hCA, 8'h88, 8'h47, 8'h08, 8'h00, 8'h00, 8'h00, 8'hFD, 8'hFF, 8'hFF, 8'hFF,
                  8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        check_bytes("t4_bytes");

        // reset during bit 4 of header byte 2, then a fresh upload
        upload(32'd0, 32'd0, 0, 0, -1, 98, cyc, err);
        @(negedge clk);
        check("t5_rst_txd", 32'(u.txd_o), 32'(1));
        check("t5_rst_busy", 32'(u.busy_o), 32'(0));
        check("t5_partial_bytes", 32'(rx_log.size()), 32'd2);
        upload(32'd0, 32'd0, 0, 0, -1, -1, cyc, err);
        check("t5_restart_cycle", 32'(cyc), 32'd481);
        check("t5_first_byte", 32'(rx_log.size() != 0 ? rx_log[0] : 8'h00), 32'hFE);

        // start while busy with size 0x20 must not disturb the header
        src_q = '{32'hA5A55A5A, 32'h12345678};
        upload(32'd8, 32'h0, 0, 0, 50, -1, cyc, err);
        check("t6_done_cycle", 32'(cyc), 32'd803);
        exp_b = '{8'hFE, 8'hCA, 8'h88, 8'h47, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h5A, 8'h5A, 8'hA5, 8'hA5, 8'h78, 8'h56, 8'h34, 8'h12};
        check_bytes("t6_bytes");

        // randomized uploads checked by the model
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(0, 5);
            sz = 32'(n * 4 + $urandom_range(0, 3));
            s = 0;
            src_q.delete();
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                src_q.push_back(w);
                s += w;
            end
            upload(sz, $urandom_range(0, 1) != 0 ? -s : $urandom, $urandom_range(0, 10), 1,
                   $urandom_range(0, 1) != 0 ? $urandom_range(1, 400) : -1, -1, cyc, err);
            check("rand_byte_count", 32'(rx_log.size()), 32'(12 + 4 * n));
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
